id_ex_pipe: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the control unit's WB/M/EX bundles.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/hazard_load_use.sv | 16 +
 rtl/id_ex_pipe.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the ID/EX stage: widths, opcodes, control-bundle bit
// positions and the all-zero bubble values loaded on stall/flush.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int WB_REGWRITE  = 0;
  localparam int WB_MEMTOREG  = 1;
  localparam int M_BRANCH     = 0;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 2;
  localparam int EX_REGDST    = 0;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC    = 4;

  localparam logic [WB_W-1:0] WB_BUBBLE = '0;
  localparam logic [M_W-1:0]  M_BUBBLE  = '0;
  localparam logic [EX_W-1:0] EX_BUBBLE = '0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
    logic            valid;
  } ctrl_t;
endpackage

// File: rtl/hazard_load_use.sv
// Load-use detector: a load in EX whose destination (rt) feeds the ID instruction.
module hazard_load_use #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall
);
  // $zero never carries a dependency
  assign stall = ex_valid & ex_memread & id_valid & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall/bubble and branch flush.
// Optional perf counters when ID_EX_PERF_EN is defined.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  input  logic [WB_W-1:0]   WB_IN,
  input  logic [M_W-1:0]    M_IN,
  input  logic [EX_W-1:0]   EX_IN,
  input  logic [DATA_W-1:0] RD1_IN,
  input  logic [DATA_W-1:0] RD2_IN,
  input  logic [DATA_W-1:0] IMM_IN,
  input  logic [DATA_W-1:0] PC4_IN,
  input  logic [REG_AW-1:0] RS_IN,
  input  logic [REG_AW-1:0] RT_IN,
  input  logic [REG_AW-1:0] RD_IN,
  input  logic              FLUSH,
  output logic [WB_W-1:0]   WB_OUT,
  output logic [M_W-1:0]    M_OUT,
  output logic [EX_W-1:0]   EX_OUT,
  output logic [DATA_W-1:0] RD1_OUT,
  output logic [DATA_W-1:0] RD2_OUT,
  output logic [DATA_W-1:0] IMM_OUT,
  output logic [DATA_W-1:0] PC4_OUT,
  output logic [REG_AW-1:0] RS_OUT,
  output logic [REG_AW-1:0] RT_OUT,
  output logic [REG_AW-1:0] RD_OUT,
  output logic              VALID_OUT,
  output logic              STALL,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              kill;

  hazard_load_use #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid   (ctrl_q.valid),
    .ex_memread (ctrl_q.m[M_MEMREAD]),
    .ex_rt      (rt_q),
    .id_valid   (ID_VALID),
    .id_rs      (RS_IN),
    .id_rt      (RT_IN),
    .stall      (STALL)
  );

  // Datapath always loads; only control and valid are squashed into a bubble.
  always_comb begin
    kill        = FLUSH | STALL | ~ID_VALID;
    ctrl_d.wb   = kill ? WB_BUBBLE : WB_IN;
    ctrl_d.m    = kill ? M_BUBBLE  : M_IN;
    ctrl_d.ex   = kill ? EX_BUBBLE : EX_IN;
    ctrl_d.valid = ~kill;
    rd1_d = RD1_IN;
    rd2_d = RD2_IN;
    imm_d = IMM_IN;
    pc4_d = PC4_IN;
    rs_d  = RS_IN;
    rt_d  = RT_IN;
    rd_d  = RD_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc4_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc4_q  <= pc4_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign WB_OUT    = ctrl_q.wb;
  assign M_OUT     = ctrl_q.m;
  assign EX_OUT    = ctrl_q.ex;
  assign VALID_OUT = ctrl_q.valid;
  assign RD1_OUT   = rd1_q;
  assign RD2_OUT   = rd2_q;
  assign IMM_OUT   = imm_q;
  assign PC4_OUT   = pc4_q;
  assign RS_OUT    = rs_q;
  assign RT_OUT    = rt_q;
  assign RD_OUT    = rd_q;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating counts: hold at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (STALL && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (FLUSH && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst_n, id_valid, flush;
  logic [1:0]    wb_in;
  logic [2:0]    m_in;
  logic [4:0]    ex_in;
  logic [DW-1:0] rd1_in, rd2_in, imm_in, pc4_in;
  logic [AW-1:0] rs_in, rt_in, rd_in;
  logic [1:0]    wb_out;
  logic [2:0]    m_out;
  logic [4:0]    ex_out;
  logic [DW-1:0] rd1_out, rd2_out, imm_out, pc4_out;
  logic [AW-1:0] rs_out, rt_out, rd_out;
  logic          valid_out, stall;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .CLK(clk), .RST_N(rst_n), .ID_VALID(id_valid),
    .WB_IN(wb_in), .M_IN(m_in), .EX_IN(ex_in),
    .RD1_IN(rd1_in), .RD2_IN(rd2_in), .IMM_IN(imm_in), .PC4_IN(pc4_in),
    .RS_IN(rs_in), .RT_IN(rt_in), .RD_IN(rd_in), .FLUSH(flush),
    .WB_OUT(wb_out), .M_OUT(m_out), .EX_OUT(ex_out),
    .RD1_OUT(rd1_out), .RD2_OUT(rd2_out), .IMM_OUT(imm_out), .PC4_OUT(pc4_out),
    .RS_OUT(rs_out), .RT_OUT(rt_out), .RD_OUT(rd_out),
    .VALID_OUT(valid_out), .STALL(stall),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction occupying EX, as a plain record
  logic [1:0]    e_wb;
  logic [2:0]    e_m;
  logic [4:0]    e_ex;
  logic [DW-1:0] e_rd1, e_rd2, e_imm, e_pc4;
  logic [AW-1:0] e_rs, e_rt, e_rd;
  bit            e_valid;
  int            e_scnt, e_fcnt;

  initial begin
    e_wb = 0; e_m = 0; e_ex = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_pc4 = 0;
    e_rs = 0; e_rt = 0; e_rd = 0; e_valid = 0; e_scnt = 0; e_fcnt = 0;
  end

  function automatic bit m_stall();
    bit ex_is_load = e_valid && e_m[1];
    bit uses_dst   = (rs_in == e_rt) || (rt_in == e_rt);
    return ex_is_load && id_valid && (e_rt != 0) && uses_dst;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      e_wb <= 0; e_m <= 0; e_ex <= 0; e_rd1 <= 0; e_rd2 <= 0; e_imm <= 0; e_pc4 <= 0;
      e_rs <= 0; e_rt <= 0; e_rd <= 0; e_valid <= 0; e_scnt <= 0; e_fcnt <= 0;
    end else begin
      if (flush || m_stall() || !id_valid) begin
        e_wb <= 0; e_m <= 0; e_ex <= 0; e_valid <= 0;
      end else begin
        e_wb <= wb_in; e_m <= m_in; e_ex <= ex_in; e_valid <= 1;
      end
      e_rd1 <= rd1_in; e_rd2 <= rd2_in; e_imm <= imm_in; e_pc4 <= pc4_in;
      e_rs <= rs_in; e_rt <= rt_in; e_rd <= rd_in;
      if (m_stall()) e_scnt <= (e_scnt < CMAX) ? e_scnt + 1 : CMAX;
      if (flush)     e_fcnt <= (e_fcnt < CMAX) ? e_fcnt + 1 : CMAX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("WB_OUT", wb_out, e_wb);
      check("M_OUT", m_out, e_m);
      check("EX_OUT", ex_out, e_ex);
      check("RD1_OUT", rd1_out, e_rd1);
      check("RD2_OUT", rd2_out, e_rd2);
      check("IMM_OUT", imm_out, e_imm);
      check("PC4_OUT", pc4_out, e_pc4);
      check("RS_OUT", rs_out, e_rs);
      check("RT_OUT", rt_out, e_rt);
      check("RD_OUT", rd_out, e_rd);
      check("VALID_OUT", valid_out, e_valid);
      check("STALL", stall, m_stall());
`ifdef ID_EX_PERF_EN
      check("STALL_CNT", stall_cnt, e_scnt);
      check("FLUSH_CNT", flush_cnt, e_fcnt);
`else
      check("STALL_CNT", stall_cnt, 0);
      check("FLUSH_CNT", flush_cnt, 0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] wb, input logic [2:0] m, input logic [4:0] ex,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input bit fl);
    id_valid = v; wb_in = wb; m_in = m; ex_in = ex;
    rs_in = rs; rt_in = rt; rd_in = rd; flush = fl;
    rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom; pc4_in = $urandom;
    #1;
  endtask

  task automatic drive_rand();
    drive(($urandom % 8) != 0, 2'($urandom), 3'($urandom), 5'($urandom),
          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom), ($urandom % 8) == 0);
  endtask

  localparam logic [4:0] EX_R  = 5'b10101;
  localparam logic [4:0] EX_LW = 5'b10000;

  initial begin
    rst_n = 0;
    drive_rand();
    cyc();
    chk_en = 1;
    drive_rand();
    cyc();
    check("rst VALID_OUT", valid_out, 0);
    check("rst WB_OUT", wb_out, 0);
    check("rst RD1_OUT", rd1_out, 0);
    check("rst STALL", stall, 0);

    // R-type right after reset release
    rst_n = 1;
    drive(1, 2'b01, 3'b000, EX_R, 5'd1, 5'd2, 5'd3, 0);
    rd1_in = 5; rd2_in = 7;
    cyc();
    check("rtype WB_OUT", wb_out, 2'b01);
    check("rtype EX_OUT", ex_out, 5'b10101);
    check("rtype RD1_OUT", rd1_out, 5);
    check("rtype RD2_OUT", rd2_out, 7);
    check("rtype VALID_OUT", valid_out, 1);

    // Load-use on rs
    drive(1, 2'b11, 3'b010, EX_LW, 5'd2, 5'd8, 5'd0, 0);
    cyc();
    drive(1, 2'b01, 3'b000, EX_R, 5'd8, 5'd9, 5'd10, 0);
    check("lu STALL", stall, 1);
    cyc();
    check("lu bubble M_OUT", m_out, 0);
    check("lu bubble VALID_OUT", valid_out, 0);
    check("lu STALL cleared", stall, 0);
    cyc();
    check("lu reissue VALID_OUT", valid_out, 1);

    // No false stalls: $zero destination, and ID bubble
    drive(1, 2'b11, 3'b010, EX_LW, 5'd1, 5'd0, 5'd0, 0);
    cyc();
    drive(1, 2'b01, 3'b000, EX_R, 5'd0, 5'd0, 5'd4, 0);
    check("rt0 STALL", stall, 0);
    cyc();
    drive(1, 2'b11, 3'b010, EX_LW, 5'd1, 5'd8, 5'd0, 0);
    cyc();
    drive(0, 2'b01, 3'b000, EX_R, 5'd8, 5'd8, 5'd4, 0);
    check("idv0 STALL", stall, 0);
    cyc();
    check("idv0 VALID_OUT", valid_out, 0);

    // Flush of an ADDI, then flush coinciding with a stall
    drive(1, 2'b01, 3'b000, 5'b10000, 5'd1, 5'd2, 5'd0, 1);
    cyc();
    check("flush VALID_OUT", valid_out, 0);
    check("flush WB_OUT", wb_out, 0);
    check("flush EX_OUT", ex_out, 0);
    drive(1, 2'b11, 3'b010, EX_LW, 5'd1, 5'd8, 5'd0, 0);
    cyc();
    drive(1, 2'b01, 3'b000, EX_R, 5'd8, 5'd3, 5'd4, 1);
    check("flush+stall STALL", stall, 1);
    cyc();
    check("flush+stall VALID_OUT", valid_out, 0);
    check("flush+stall STALL cleared", stall, 0);
    drive(1, 2'b01, 3'b000, EX_R, 5'd8, 5'd3, 5'd4, 0);
    cyc();

    // Load-use on rt
    drive(1, 2'b11, 3'b010, EX_LW, 5'd1, 5'd8, 5'd0, 0);
    cyc();
    drive(1, 2'b01, 3'b000, EX_R, 5'd5, 5'd8, 5'd4, 0);
    check("lu-rt STALL", stall, 1);
    cyc();
    cyc();
`ifdef ID_EX_PERF_EN
    check("perf STALL_CNT=3", stall_cnt, 3);
    check("perf FLUSH_CNT=2", flush_cnt, 2);
`else
    check("noperf STALL_CNT", stall_cnt, 0);
    check("noperf FLUSH_CNT", flush_cnt, 0);
`endif

    // Drive the stall counter past its maximum
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'b11, 3'b010, EX_LW, 5'd1, 5'd8, 5'd0, 0);
      cyc();
      drive(1, 2'b01, 3'b000, EX_R, 5'd8, 5'd2, 5'd4, 0);
      cyc();
      cyc();
    end
`ifdef ID_EX_PERF_EN
    check("perf STALL_CNT saturated", stall_cnt, 4'hF);
`else
    check("noperf STALL_CNT after loop", stall_cnt, 0);
`endif

    // Randomized traffic with occasional mid-stream resets
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom % 64) != 0;
      drive_rand();
      cyc();
    end

    rst_n = 0;
    drive_rand();
    cyc();
    check("final rst VALID_OUT", valid_out, 0);
    check("final rst STALL_CNT", stall_cnt, 0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
